// File: rtl/data_frame_codec_if.sv
`default_nettype none
// ============================================================================
// Module   : data_frame_codec_if
// Purpose  : Receive/transmit bundle between the frame codec and its peers.
// Revision : 1.0  initial release
// ============================================================================
interface data_frame_codec_if #(
   parameter int NCHARS = 10,
   parameter int CODE_W = 8
) ();
   logic [7:0]                     rx_byte;
   logic                           rx_valid;
   logic [NCHARS*CODE_W-1:0]       frame_out;
   logic [$clog2(NCHARS+1)-1:0]    frame_len;
   logic                           frame_valid;
   logic                           err_unmapped;
   logic [NCHARS*CODE_W-1:0]       frame_in;
   logic                           send;
   logic                           send_busy;
   logic [7:0]                     tx_byte;
   logic                           tx_stb;
   logic                           tx_busy;

   modport slave (
      input  rx_byte, rx_valid, frame_in, send, tx_busy,
      output frame_out, frame_len, frame_valid, err_unmapped,
             send_busy, tx_byte, tx_stb
   );

   modport master (
      output rx_byte, rx_valid, frame_in, send, tx_busy,
      input  frame_out, frame_len, frame_valid, err_unmapped,
             send_busy, tx_byte, tx_stb
   );
endinterface
`default_nettype wire

// File: rtl/data_frame_codec.sv
`default_nettype none
// ============================================================================
// Module   : data_frame_codec
// Purpose  : ASCII <-> 6-bit character code framer with independent RX/TX.
// Revision : 1.0  initial release
// ============================================================================
module data_frame_codec #(
   parameter int         NCHARS      = 10,
   parameter int         CODE_W      = 8,
   parameter logic [7:0] TERM_CHAR   = 8'h0D,
   parameter bit         APPEND_TERM = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   data_frame_codec_if.slave bus
);
   localparam int c_frame_w = NCHARS * CODE_W;
   localparam int c_cnt_w   = $clog2(NCHARS + 1);
   localparam int c_idx_w   = (NCHARS > 1) ? $clog2(NCHARS) : 1;
   localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(NCHARS - 1);
   localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(NCHARS);
   localparam logic [c_idx_w-1:0] c_idx_top = c_idx_w'(NCHARS - 1);

   generate
      if (CODE_W < 7 || CODE_W > 8) begin : g_bad_code_w
         $error("data_frame_codec: CODE_W must be 7 or 8");
      end
      if (NCHARS < 1 || NCHARS > 32) begin : g_bad_nchars
         $error("data_frame_codec: NCHARS must be in 1..32");
      end
   endgenerate

   // Forward map yields 0..64; 64 marks an unmapped byte.
   function automatic logic [6:0] fwd_map(input logic [7:0] b);
      logic [7:0] t;
      if (b >= 8'h30 && b <= 8'h39)      t = b - 8'h30;
      else if (b >= 8'h41 && b <= 8'h5A) t = b - 8'h37;
      else if (b >= 8'h61 && b <= 8'h7A) t = b - 8'h3D;
      else if (b == 8'h3F)               t = 8'd62;
      else if (b == 8'h21)               t = 8'd63;
      else                               t = 8'd64;
      return t[6:0];
   endfunction

   function automatic logic [7:0] rev_map(input logic [CODE_W-1:0] code);
      logic [7:0] c8;
      logic [7:0] b;
      c8 = '0;
      c8[CODE_W-1:0] = code;
      if (c8 < 8'd10)       b = c8 + 8'h30;
      else if (c8 < 8'd36)  b = c8 + 8'h37;
      else if (c8 < 8'd62)  b = c8 + 8'h3D;
      else if (c8 == 8'd62) b = 8'h3F;
      else if (c8 == 8'd63) b = 8'h21;
      else                  b = 8'h23;
      return b;
   endfunction

   // ---------------------------------------------------------------- receive
   logic [c_frame_w-1:0] r_shift;
   logic [c_cnt_w-1:0]   r_count;
   logic [c_frame_w-1:0] r_frame_out;
   logic [c_cnt_w-1:0]   r_frame_len;
   logic                 r_frame_valid;
   logic                 r_err_unmapped;

   logic                 w_is_term;
   logic [6:0]           w_code;
   logic [c_frame_w-1:0] w_code_ext;
   logic [c_frame_w-1:0] w_shift_nxt;

   always_comb begin
      w_is_term          = (bus.rx_byte == TERM_CHAR);
      w_code             = fwd_map(bus.rx_byte);
      w_code_ext         = '0;
      w_code_ext[6:0]    = w_code;
      w_shift_nxt        = (r_shift << CODE_W) | w_code_ext;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_shift        <= '0;
         r_count        <= '0;
         r_frame_out    <= '0;
         r_frame_len    <= '0;
         r_frame_valid  <= 1'b0;
         r_err_unmapped <= 1'b0;
      end else begin
         r_frame_valid  <= 1'b0;
         r_err_unmapped <= 1'b0;
         if (bus.rx_valid) begin
            if (w_is_term) begin
               // A terminator on an empty buffer carries no frame.
               if (r_count != '0) begin
                  r_frame_out   <= r_shift;
                  r_frame_len   <= r_count;
                  r_frame_valid <= 1'b1;
                  r_shift       <= '0;
                  r_count       <= '0;
               end
            end else begin
               r_err_unmapped <= (w_code == 7'd64);
               if (r_count == c_last) begin
                  r_frame_out   <= w_shift_nxt;
                  r_frame_len   <= c_full;
                  r_frame_valid <= 1'b1;
                  r_shift       <= '0;
                  r_count       <= '0;
               end else begin
                  r_shift <= w_shift_nxt;
                  r_count <= r_count + c_cnt_w'(1);
               end
            end
         end
      end
   end

   assign bus.frame_out    = r_frame_out;
   assign bus.frame_len    = r_frame_len;
   assign bus.frame_valid  = r_frame_valid;
   assign bus.err_unmapped = r_err_unmapped;

   // --------------------------------------------------------------- transmit
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STROBE = 3'd1,
      S_ACK    = 3'd2,
      S_DRAIN  = 3'd3,
      S_TERM   = 3'd4
   } tx_state_t;

   tx_state_t            r_state;
   tx_state_t            w_state_nxt;
   logic [c_frame_w-1:0] r_tx_frame;
   logic [c_idx_w-1:0]   r_idx;
   logic                 r_in_term;

   logic                 w_load;
   logic                 w_idx_dec;
   logic                 w_term_sent;
   logic                 w_tx_stb;
   logic [7:0]           w_tx_byte;
   logic [c_frame_w-1:0] w_tx_shifted;
   logic [CODE_W-1:0]    w_cur_code;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_tx_frame <= '0;
         r_idx      <= '0;
         r_in_term  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_tx_frame <= bus.frame_in;
            r_idx      <= c_idx_top;
            r_in_term  <= 1'b0;
         end
         if (w_idx_dec)   r_idx     <= r_idx - c_idx_w'(1);
         if (w_term_sent) r_in_term <= 1'b1;
      end
   end

   // Strobe is gated combinationally by tx_busy so it can never overlap busy.
   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_idx_dec    = 1'b0;
      w_term_sent  = 1'b0;
      w_tx_stb     = 1'b0;
      w_tx_byte    = '0;
      w_tx_shifted = r_tx_frame >> (32'(r_idx) * CODE_W);
      w_cur_code   = w_tx_shifted[CODE_W-1:0];
      case (r_state)
         S_IDLE: begin
            if (bus.send) begin
               w_load      = 1'b1;
               w_state_nxt = S_STROBE;
            end
         end
         S_STROBE: begin
            if (!bus.tx_busy) begin
               w_tx_stb    = 1'b1;
               w_tx_byte   = rev_map(w_cur_code);
               w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!bus.tx_busy) begin
               if (r_in_term) begin
                  w_state_nxt = S_IDLE;
               end else if (r_idx == '0) begin
                  w_state_nxt = APPEND_TERM ? S_TERM : S_IDLE;
               end else begin
                  w_idx_dec   = 1'b1;
                  w_state_nxt = S_STROBE;
               end
            end
         end
         S_TERM: begin
            if (!bus.tx_busy) begin
               w_tx_stb    = 1'b1;
               w_tx_byte   = TERM_CHAR;
               w_term_sent = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.tx_stb    = w_tx_stb;
   assign bus.tx_byte   = w_tx_byte;
   assign bus.send_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_frame_codec.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_frame_codec
// Purpose  : Directed self-checking bench for data_frame_codec.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_frame_codec;
   localparam int NCHARS = 10;
   localparam int CODE_W = 8;

   logic clk;
   logic rst;

   data_frame_codec_if #(.NCHARS(NCHARS), .CODE_W(CODE_W)) bus ();

   data_frame_codec #(
      .NCHARS      (NCHARS),
      .CODE_W      (CODE_W),
      .TERM_CHAR   (8'h0D),
      .APPEND_TERM (1'b1)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic rx_put(input logic [7:0] b);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   logic [7:0] got_bytes [0:15];
   int n_strb;
   int viol;
   int last_stb_cyc;
   int idle_cyc;

   // Runs a transmission against a UART model that stays busy 5 cycles after
   // each strobe; returns at send_busy low or after stop_after strobes.
   task automatic tx_run(input int stop_after, input bit mix_rx);
      int busy_cnt = 0;
      int cyc      = 0;
      bit done     = 1'b0;
      n_strb       = 0;
      viol         = 0;
      last_stb_cyc = -1;
      idle_cyc     = -1;
      bus.send     = 1'b1;
      if (mix_rx) begin
         bus.rx_byte  = 8'h5A;
         bus.rx_valid = 1'b1;
      end
      while (!done && cyc < 600) begin
         @(posedge clk); #1;
         cyc++;
         bus.send     = 1'b0;
         bus.rx_valid = 1'b0;
         if (mix_rx && cyc == 2) begin
            bus.rx_byte  = 8'h0D;
            bus.rx_valid = 1'b1;
         end
         if (mix_rx && cyc == 3) begin
            chk("rx_during_tx_valid", bus.frame_valid, 1'b1);
            chk("rx_during_tx_frame", bus.frame_out, 80'h23);
            chk("rx_during_tx_len", bus.frame_len, 4'd1);
         end
         if (cyc == 4) begin
            bus.frame_in = {10{8'h3F}};
            bus.send     = 1'b1;
         end
         bus.tx_busy = (busy_cnt > 0);
         if (busy_cnt > 0) busy_cnt--;
         @(negedge clk);
         if (bus.tx_stb) begin
            if (bus.tx_busy) viol++;
            if (n_strb < 16) got_bytes[n_strb] = bus.tx_byte;
            n_strb++;
            busy_cnt     = 5;
            last_stb_cyc = cyc;
            if (n_strb == stop_after) done = 1'b1;
         end else if (!bus.send_busy) begin
            idle_cyc = cyc;
            done     = 1'b1;
         end
      end
      if (!done) chk("tx_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      int pulses;
      int stb_after_rst;
      logic [7:0] str_a [0:9];

      rst           = 1'b0;
      bus.rx_byte   = '0;
      bus.rx_valid  = 1'b0;
      bus.frame_in  = '0;
      bus.send      = 1'b0;
      bus.tx_busy   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_frame_out", bus.frame_out, '0);
      chk("rst_frame_len", bus.frame_len, '0);
      chk("rst_frame_valid", bus.frame_valid, 1'b0);
      chk("rst_err", bus.err_unmapped, 1'b0);
      chk("rst_send_busy", bus.send_busy, 1'b0);
      chk("rst_tx_stb", bus.tx_stb, 1'b0);
      chk("rst_tx_byte", bus.tx_byte, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1;

      // Full frame "ABCDEFGHIJ"
      for (int i = 0; i < 10; i++) str_a[i] = 8'h41 + 8'(i);
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         rx_put(str_a[i]);
         if (bus.frame_valid) pulses++;
      end
      chk("full_no_early_valid", pulses, 0);
      rx_put(str_a[9]);
      chk("full_valid", bus.frame_valid, 1'b1);
      chk("full_frame", bus.frame_out, 80'h0A0B0C0D0E0F10111213);
      chk("full_len", bus.frame_len, 4'd10);
      @(posedge clk); #1;
      chk("full_valid_one_cycle", bus.frame_valid, 1'b0);
      chk("full_frame_hold", bus.frame_out, 80'h0A0B0C0D0E0F10111213);

      // Partial frame "a9" + terminator, then lone terminator
      rx_put(8'h61);
      rx_put(8'h39);
      chk("part_no_early_valid", bus.frame_valid, 1'b0);
      rx_put(8'h0D);
      chk("part_valid", bus.frame_valid, 1'b1);
      chk("part_len", bus.frame_len, 4'd2);
      chk("part_frame", bus.frame_out, 80'h2409);
      @(posedge clk); #1;
      rx_put(8'h0D);
      chk("lone_term_no_valid", bus.frame_valid, 1'b0);
      chk("lone_term_hold", bus.frame_out, 80'h2409);

      // Unmapped byte
      rx_put(8'h2A);
      chk("unmapped_err", bus.err_unmapped, 1'b1);
      chk("unmapped_no_valid", bus.frame_valid, 1'b0);
      rx_put(8'h0D);
      chk("unmapped_err_one_cycle", bus.err_unmapped, 1'b0);
      chk("unmapped_code", bus.frame_out, 80'h40);
      chk("unmapped_len", bus.frame_len, 4'd1);

      // Transmit "0123456789" + CR, with simultaneous receive and ignored send
      bus.frame_in = 80'h00010203040506070809;
      tx_run(0, 1'b1);
      chk("tx_count", n_strb, 11);
      for (int i = 0; i < 10; i++)
         chk($sformatf("tx_byte%0d", i), got_bytes[i], 8'h30 + 8'(i));
      chk("tx_term", got_bytes[10], 8'h0D);
      chk("tx_no_stb_while_busy", viol, 0);
      chk("tx_busy_falls_after_last", (idle_cyc > last_stb_cyc), 1'b1);
      chk("tx_idle_send_busy", bus.send_busy, 1'b0);

      // Reset after the third strobe
      bus.frame_in = 80'h00010203040506070809;
      tx_run(3, 1'b0);
      chk("rst_run_third", got_bytes[2], 8'h32);
      rst         = 1'b0;
      bus.tx_busy = 1'b0;
      @(posedge clk); #1;
      chk("midrst_send_busy", bus.send_busy, 1'b0);
      chk("midrst_tx_stb", bus.tx_stb, 1'b0);
      chk("midrst_frame_out", bus.frame_out, '0);
      rst = 1'b1;
      stb_after_rst = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.tx_stb) stb_after_rst++;
      end
      chk("midrst_no_stb", stb_after_rst, 0);
      @(posedge clk); #1;
      bus.frame_in = 80'h00010203040506070809;
      tx_run(1, 1'b0);
      chk("restart_first", got_bytes[0], 8'h30);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
